// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel edge-detection core.
//   LAT            : clocks from an accepted input pixel to its registered result
//   dir_e          : quantised gradient-direction codes (used when SOBEL_EDGE_DIR_EN is defined)
//   grad_w()       : default width of the |Gx|+|Gy| magnitude for a given luma width
package sobel_pkg;

  localparam int unsigned LAT = 4;

  typedef enum logic [1:0] {
    DIR_H    = 2'b00,
    DIR_V    = 2'b01,
    DIR_D45  = 2'b10,
    DIR_D135 = 2'b11
  } dir_e;

  // 8*(2^data_w - 1) needs exactly data_w+3 bits
  function automatic int unsigned grad_w(input int unsigned data_w);
    return data_w + 32'd3;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line delay buffer for the Sobel window.
//   clk, rst : clock, synchronous active-high reset (address only; contents are not reset)
//   en       : advance strobe; writes din and steps the address
//   clr      : return the address to column 0 (line start)
//   din      : pixel written at the current address
//   dout_c   : combinational read of the current address (value before this cycle's write)
module sobel_line_buffer #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    addr;

  // Read-before-write: the write lands at the clock edge, so this cycle sees the old word
  assign dout_c = mem[addr];

  // Address wraps modulo DEPTH so over-long lines stay in range
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      addr <= '0;
    end else if (en) begin
      addr <= (addr == ADDR_LAST) ? '0 : addr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= din;
    end
  end

endmodule

// File: rtl/sobel_edge_core.sv
// Streaming 3x3 Sobel edge detector with runtime threshold and saturated magnitude.
// Optional macro SOBEL_EDGE_DIR_EN adds the quantised direction output out_img_dir.
//   clk, rst              : pixel clock, synchronous active-high reset
//   threshold             : edge threshold, edge when |Gx|+|Gy| > threshold
//   in_frame_vsync/href/clken, in_img_Y : capture-side sync and luma
//   out_frame_vsync/href/clken          : input sync delayed by LAT clocks
//   out_img_Bit           : edge flag for the window centre (row-1, col-1)
//   out_img_mag           : min(|Gx|+|Gy|, 2^DATA_W-1)
//   out_img_dir           : direction code (SOBEL_EDGE_DIR_EN only)
module sobel_edge_core
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W  = 1024,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned GRAD_W = grad_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GRAD_W-1:0] threshold,
  input  logic              in_frame_vsync,
  input  logic              in_frame_href,
  input  logic              in_frame_clken,
  input  logic [DATA_W-1:0] in_img_Y,
  output logic              out_frame_vsync,
  output logic              out_frame_href,
  output logic              out_frame_clken,
  output logic              out_img_Bit,
  output logic [DATA_W-1:0] out_img_mag
`ifdef SOBEL_EDGE_DIR_EN
 ,output logic [1:0]        out_img_dir
`endif
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = 16;
  localparam int unsigned SW = GRAD_W + 1;
  localparam logic [CW-1:0]     COL_MAX = CW'(IMG_W - 1);
  localparam logic [GRAD_W-1:0] PIX_MAX = GRAD_W'({DATA_W{1'b1}});

  // Sync edge detection and position counters
  logic          vsync_q, href_q;
  logic          href_fall_c, vsync_rise_c, border_c;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  assign href_fall_c  = href_q & ~in_frame_href;
  assign vsync_rise_c = in_frame_vsync & ~vsync_q;
  assign border_c     = (row_cnt < RW'(2)) || (col_cnt < CW'(2));

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= in_frame_vsync;
      href_q  <= in_frame_href;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || href_fall_c) begin
      col_cnt <= '0;
    end else if (in_frame_clken && (col_cnt != COL_MAX)) begin
      col_cnt <= col_cnt + CW'(1);
    end
  end

  // vsync rising takes priority over a coincident line end
  always_ff @(posedge clk) begin
    if (rst || vsync_rise_c) begin
      row_cnt <= '0;
    end else if (href_fall_c && (row_cnt != '1)) begin
      row_cnt <= row_cnt + RW'(1);
    end
  end

  // Two cascaded line buffers: lb0 gives row r-1, lb1 gives row r-2
  logic [DATA_W-1:0] lb0_q_c, lb1_q_c;

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb0 (
    .clk    (clk),
    .rst    (rst),
    .en     (in_frame_clken),
    .clr    (href_fall_c),
    .din    (in_img_Y),
    .dout_c (lb0_q_c)
  );

  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb1 (
    .clk    (clk),
    .rst    (rst),
    .en     (in_frame_clken),
    .clr    (href_fall_c),
    .din    (lb0_q_c),
    .dout_c (lb1_q_c)
  );

  // Stage 1: 3x3 window, win[row][col]; row 0 = oldest line, col 2 = newest pixel
  logic [DATA_W-1:0] win [3][3];
  logic              s1_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win[i][j] <= '0;
        end
      end
    end else if (in_frame_clken) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb1_q_c;
      win[1][2] <= lb0_q_c;
      win[2][2] <= in_img_Y;
    end
  end

  // Idle cycles are masked too, so the result is zero whenever out_frame_clken is low
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_mask <= 1'b1;
    end else begin
      s1_mask <= ~in_frame_clken | border_c;
    end
  end

  // Stage 2: signed gradients
  logic [SW-1:0]        gx_pos_c, gx_neg_c, gy_pos_c, gy_neg_c;
  logic signed [SW-1:0] gx_q, gy_q;
  logic                 s2_mask;

  assign gx_pos_c = SW'(win[0][2]) + (SW'(win[1][2]) << 1) + SW'(win[2][2]);
  assign gx_neg_c = SW'(win[0][0]) + (SW'(win[1][0]) << 1) + SW'(win[2][0]);
  assign gy_pos_c = SW'(win[2][0]) + (SW'(win[2][1]) << 1) + SW'(win[2][2]);
  assign gy_neg_c = SW'(win[0][0]) + (SW'(win[0][1]) << 1) + SW'(win[0][2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      gx_q    <= '0;
      gy_q    <= '0;
      s2_mask <= 1'b1;
    end else begin
      gx_q    <= $signed(gx_pos_c - gx_neg_c);
      gy_q    <= $signed(gy_pos_c - gy_neg_c);
      s2_mask <= s1_mask;
    end
  end

  // Stage 3: |Gx| + |Gy|
  logic [SW-1:0]     gx_abs_c, gy_abs_c;
  logic [GRAD_W-1:0] s3_sum;
  logic              s3_mask;

  assign gx_abs_c = gx_q[SW-1] ? (SW'(0) - $unsigned(gx_q)) : $unsigned(gx_q);
  assign gy_abs_c = gy_q[SW-1] ? (SW'(0) - $unsigned(gy_q)) : $unsigned(gy_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_sum  <= '0;
      s3_mask <= 1'b1;
    end else begin
      s3_sum  <= GRAD_W'(gx_abs_c + gy_abs_c);
      s3_mask <= s2_mask;
    end
  end

  // Stage 4: threshold and saturate; threshold is taken live on this transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_img_Bit <= 1'b0;
      out_img_mag <= '0;
    end else begin
      out_img_Bit <= ~s3_mask & (s3_sum > threshold);
      out_img_mag <= s3_mask ? '0 : DATA_W'((s3_sum > PIX_MAX) ? PIX_MAX : s3_sum);
    end
  end

`ifdef SOBEL_EDGE_DIR_EN
  // Direction: component magnitudes and diagonal sign carried alongside the sum
  logic [GRAD_W-1:0] s3_ax, s3_ay;
  logic              s3_diag_pos;
  logic [GRAD_W:0]   ax2_c, ay2_c;
  dir_e              dir_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_ax       <= '0;
      s3_ay       <= '0;
      s3_diag_pos <= 1'b0;
    end else begin
      s3_ax       <= GRAD_W'(gx_abs_c);
      s3_ay       <= GRAD_W'(gy_abs_c);
      s3_diag_pos <= (gx_q != '0) && (gy_q != '0) && (gx_q[SW-1] == gy_q[SW-1]);
    end
  end

  always_comb begin
    ax2_c = {s3_ax, 1'b0};
    ay2_c = {s3_ay, 1'b0};
    dir_c = DIR_D135;
    if ({1'b0, s3_ay} >= ax2_c) begin
      dir_c = DIR_H;
    end else if ({1'b0, s3_ax} >= ay2_c) begin
      dir_c = DIR_V;
    end else if (s3_diag_pos) begin
      dir_c = DIR_D45;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_img_dir <= DIR_H;
    end else begin
      out_img_dir <= s3_mask ? DIR_H : dir_c;
    end
  end
`endif

  // Sync delay lines, same depth as the data pipeline
  logic [LAT-1:0] vs_d, hr_d, ce_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d <= '0;
      hr_d <= '0;
      ce_d <= '0;
    end else begin
      vs_d <= {vs_d[LAT-2:0], in_frame_vsync};
      hr_d <= {hr_d[LAT-2:0], in_frame_href};
      ce_d <= {ce_d[LAT-2:0], in_frame_clken};
    end
  end

  assign out_frame_vsync = vs_d[LAT-1];
  assign out_frame_href  = hr_d[LAT-1];
  assign out_frame_clken = ce_d[LAT-1];

endmodule
